ps2_scan_ctrl: RTL and testbench
================================

// Module: ps2_scan_ctrl
// PURPOSE
//  Sequencer between the ps2_keyboard receive FIFO and downstream logic. Pops scan-code
//  bytes via the ready/nextdata_n handshake, parses E0/F0 prefixes into whole key events
//  and tracks Shift/CapsLock. Emits one event per key action on a valid/ready port, with
//  ASCII. Replaces ad-hoc pop/parse FSMs in top-level display logic.
// PARAMETERS
//  CNT_W      8    width of key_cnt (wraps modulo 2^CNT_W)
// PORTS
//  clk            in   1  system clock; single clock domain
//  clrn           in   1  reset, synchronous, active-low
//  fifo_data      in   8  ps2_keyboard.data (head of FIFO)
//  fifo_ready     in   1  ps2_keyboard.ready (FIFO non-empty)
//  fifo_overflow  in   1  ps2_keyboard.overflow
//  fifo_nextdata_n out 1  ps2_keyboard.nextdata_n; low for exactly 1 cycle = pop
//  evt_valid      out  1  key event available
//  evt_ready      in   1  downstream accepts event (transfer when valid&ready)
//  evt_code       out  8  final scan code (prefixes stripped)
//  evt_ext        out  1  event was E0-prefixed
//  evt_break      out  1  1 = release (F0 seen), 0 = press
//  evt_repeat     out  1  press of a code already held (typematic)
//  evt_ascii      out  8  ASCII of press; 8'h00 for break, ext or unmapped codes
//  shift_held     out  1  either Shift (12/59, non-ext) currently down
//  caps_lock      out  1  CapsLock toggle state
//  key_cnt        out  CNT_W  count of non-repeat press events
//  overflow_seen  out  1  sticky copy of fifo_overflow
// BEHAVIOUR
//  Reset (clrn=0 at clk edge): state=IDLE, fifo_nextdata_n=1, all evt_* = 0,
//   shift_held=caps_lock=0, key_cnt=0, overflow_seen=0, prefix flags and held code
//   cleared. Applies mid-sequence; any partial prefix is discarded, no pop issued.
//  FSM (all registered):
//   IDLE:  fifo_ready=1 -> latch fifo_data into byte_q, drive fifo_nextdata_n<=0, ->POP.
//   POP:   fifo_nextdata_n<=1 (low exactly one cycle), ->CLASS.
//   CLASS: byte_q==E0 -> ext_f<=1, ->IDLE; byte_q==F0 -> brk_f<=1, ->IDLE;
//          else load evt_* from byte_q/ext_f/brk_f, evt_valid<=1, ->EMIT.
//   EMIT:  hold all evt_* stable; on evt_valid&evt_ready: evt_valid<=0,
//          ext_f<=0, brk_f<=0, ->IDLE. No pops while in EMIT or CLASS (backpressure
//          leaves bytes in the FIFO; FIFO overflow is then reported, not prevented).
//  Latency: fifo_ready sampled high in cycle N -> evt_valid high from cycle N+3.
//   Min 3 cycles between consecutive pops; ready is never re-sampled in POP.
//  Held-key tracking: press stores {ext,code} in held_q; press matching held_q sets
//   evt_repeat=1; break matching held_q clears held_q. Break never sets evt_repeat.
//  Side effects applied at CLASS->EMIT (once per event, independent of evt_ready timing):
//   key_cnt +1 on press with repeat=0, wraps all-ones -> 0.
//   Shift: non-ext 12/59 press sets shift_held, break clears it (one flag for both).
//   CapsLock 58 press with repeat=0 toggles caps_lock; repeats and breaks do not.
//  ASCII (press, non-ext only): 1C..1A letter codes -> 'a'..'z', or 'A'..'Z' when
//   shift_held XOR caps_lock (shift state before this event's own update);
//   45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9' (shift ignored); 29->20, 5A->0D,
//   66->08; all else 00.
//  overflow_seen <= 1 when fifo_overflow=1; cleared only by reset.
//  E0 F0 xx: ext=1, break=1. Repeated prefixes (E0 E0) are idempotent.
// STRUCTURE
//  Package ps2_pkg: state localparams (IDLE/POP/CLASS/EMIT), scan constants
//   SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58.
//  Sub-module ps2_ascii_lut: combinational {code[7:0], upper} -> ascii[7:0].
//  Everything else (FSM, flags, counters) stays in ps2_scan_ctrl.
// TESTING
//  1C F0 1C, evt_ready=1 -> press code=1C ascii=61 cnt=1, then break code=1C ascii=00.
//  12, 1C, F0 1C, F0 12 -> shift_held=1, 'A'(41) press, shift_held=0 after last break.
//  58 F0 58, then 32 -> caps_lock=1, ascii=42; 58 again toggles back, 32 -> 62.
//  1C 1C 1C (typematic) -> 3 presses, repeat=0,1,1, key_cnt +1 only.
//  E0 75 / E0 F0 75 -> ext=1 code=75 ascii=00, break=1 on second; pops 2 and 3 bytes.
//  evt_ready=0 for 20 cycles with bytes queued -> evt_* stable, nextdata_n stays 1;
//   clrn low mid E0 prefix -> all outputs at reset values, next 74 has ext=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 scan-code sequencer.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_CLASS = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
  } key_evt_t;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational scan-code (set 2) to ASCII translation for a non-extended press.
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic [4:0] letter_idx;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    letter_idx = 5'd31;
    ascii      = 8'h00;
    case (code)
      8'h1C: letter_idx = 5'd0;   8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;   8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;   8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;   8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;   8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;  8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;  8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;  8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;  8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;  8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;  8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;  8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;  8'h1A: letter_idx = 5'd25;
      default: letter_idx = 5'd31;
    endcase

    if (letter_idx != 5'd31) begin
      ascii = (upper ? 8'h41 : 8'h61) + {3'b000, letter_idx};
    end else begin
      // Digits ignore the shift/caps state.
      case (code)
        8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;
        8'h1E: ascii = 8'h32;  8'h26: ascii = 8'h33;
        8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;
        8'h3E: ascii = 8'h38;  8'h46: ascii = 8'h39;
        8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;
        8'h66: ascii = 8'h08;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Pops PS/2 scan-code bytes from the keyboard FIFO, folds E0/F0 prefixes into whole
// key events, tracks Shift/CapsLock/held key and offers each event on a valid/ready port.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ready,
  input  logic             fifo_overflow,
  output logic             fifo_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic [7:0]       evt_ascii,
  output logic             shift_held,
  output logic             caps_lock,
  output logic [CNT_W-1:0] key_cnt,
  output logic             overflow_seen
);

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             valid_q, valid_d;
  key_evt_t         evt_q, evt_d;
  logic             held_v_q, held_v_d;
  logic [8:0]       held_q, held_d;
  logic             shift_q, shift_d;
  logic             caps_q, caps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [8:0] key;
  logic       held_hit;
  logic       is_rep;
  logic [7:0] lut_ascii;

  assign key      = {ext_q, byte_q};
  assign held_hit = held_v_q && (held_q == key);
  assign is_rep   = !brk_q && held_hit;

  // Case is chosen from the shift/caps state before this event updates it.
  ps2_ascii_lut u_lut (
    .code  (byte_q),
    .upper (shift_q ^ caps_q),
    .ascii (lut_ascii)
  );

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    nextdata_n_d = nextdata_n_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    valid_d      = valid_q;
    evt_d        = evt_q;
    held_v_d     = held_v_q;
    held_d       = held_q;
    shift_d      = shift_q;
    caps_d       = caps_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q | fifo_overflow;

    case (state_q)
      ST_IDLE: begin
        if (fifo_ready) begin
          byte_d       = fifo_data;
          nextdata_n_d = 1'b0;
          state_d      = ST_POP;
        end
      end
      ST_POP: begin
        nextdata_n_d = 1'b1;
        state_d      = ST_CLASS;
      end
      ST_CLASS: begin
        if (byte_q == SC_EXT) begin
          ext_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (byte_q == SC_BRK) begin
          brk_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          evt_d.code  = byte_q;
          evt_d.ext   = ext_q;
          evt_d.brk   = brk_q;
          evt_d.rep   = is_rep;
          evt_d.ascii = (brk_q || ext_q) ? 8'h00 : lut_ascii;
          valid_d     = 1'b1;
          state_d     = ST_EMIT;

          // Side effects happen once here, never in EMIT, so downstream stalls cannot repeat them.
          if (!brk_q) begin
            held_v_d = 1'b1;
            held_d   = key;
            if (!is_rep) cnt_d = cnt_q + CNT_W'(1);
          end else if (held_hit) begin
            held_v_d = 1'b0;
          end
          if (!ext_q && (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT)) shift_d = !brk_q;
          if (!ext_q && byte_q == SC_CAPS && !brk_q && !is_rep) caps_d = !caps_q;
        end
      end
      ST_EMIT: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; every flop, data included, is reset.
    if (!clrn) begin
      state_q      <= ST_IDLE;
      byte_q       <= '0;
      nextdata_n_q <= 1'b1;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      valid_q      <= 1'b0;
      evt_q        <= '0;
      held_v_q     <= 1'b0;
      held_q       <= '0;
      shift_q      <= 1'b0;
      caps_q       <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      valid_q      <= valid_d;
      evt_q        <= evt_d;
      held_v_q     <= held_v_d;
      held_q       <= held_d;
      shift_q      <= shift_d;
      caps_q       <= caps_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign fifo_nextdata_n = nextdata_n_q;
  assign evt_valid       = valid_q;
  assign evt_code        = evt_q.code;
  assign evt_ext         = evt_q.ext;
  assign evt_break       = evt_q.brk;
  assign evt_repeat      = evt_q.rep;
  assign evt_ascii       = evt_q.ascii;
  assign shift_held      = shift_q;
  assign caps_lock       = caps_q;
  assign key_cnt         = cnt_q;
  assign overflow_seen   = ovf_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: queue-based FIFO, event-level reference model,
// per-cycle comparison on the falling edge, directed scenarios plus randomized traffic.
module tb_ps2_scan_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_overflow;
  logic       fifo_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_repeat;
  logic [7:0] evt_ascii;
  logic       shift_held;
  logic       caps_lock;
  logic [7:0] key_cnt;
  logic       overflow_seen;

  ps2_scan_ctrl #(.CNT_W(8)) dut (
    .clk             (clk),
    .clrn            (clrn),
    .fifo_data       (fifo_data),
    .fifo_ready      (fifo_ready),
    .fifo_overflow   (fifo_overflow),
    .fifo_nextdata_n (fifo_nextdata_n),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_code        (evt_code),
    .evt_ext         (evt_ext),
    .evt_break       (evt_break),
    .evt_repeat      (evt_repeat),
    .evt_ascii       (evt_ascii),
    .shift_held      (shift_held),
    .caps_lock       (caps_lock),
    .key_cnt         (key_cnt),
    .overflow_seen   (overflow_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
    logic       shift;
    logic       caps;
    logic [7:0] cnt;
    int         pop_cyc;
  } exp_t;

  localparam logic [7:0] LETTER_SC [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_SC [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] RAND_POOL [12] = '{
    8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h58, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h75};

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int pops     = 0;

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  exp_t       log_q[$];

  // Reference model state (event level) and the state visible after the last transfer.
  logic       m_ext, m_brk, m_shift, m_caps, m_held_v, m_ovf;
  logic [8:0] m_held;
  int         m_cnt;
  logic       v_shift, v_caps;
  logic [7:0] v_cnt;
  logic       prev_nd, prev_valid;
  exp_t       e_cur;
  exp_t       l_ent;
  logic [7:0] b_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic up);
    for (int i = 0; i < 26; i++)
      if (c == LETTER_SC[i]) return up ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (c == DIGIT_SC[i]) return 8'(48 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_shift = 0; m_caps = 0; m_held_v = 0; m_held = '0;
    m_cnt = 0; m_ovf = 0; v_shift = 0; v_caps = 0; v_cnt = 0;
    prev_nd = 1; prev_valid = 0;
    fifo_q.delete();
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int pc);
    exp_t       e;
    logic [8:0] k;
    logic       hit;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k       = {m_ext, b};
      hit     = m_held_v && (m_held == k);
      e.code  = b;
      e.ext   = m_ext;
      e.brk   = m_brk;
      e.rep   = !m_brk && hit;
      e.ascii = (m_brk || m_ext) ? 8'h00 : ref_ascii(b, m_shift ^ m_caps);
      if (!m_brk) begin
        m_held_v = 1; m_held = k;
        if (!e.rep) m_cnt = (m_cnt + 1) % 256;
      end else if (hit) m_held_v = 0;
      if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
      if (!m_ext && b == 8'h58 && !m_brk && !e.rep) m_caps = !m_caps;
      e.shift   = m_shift;
      e.caps    = m_caps;
      e.cnt     = 8'(m_cnt);
      e.pop_cyc = pc;
      exp_q.push_back(e);
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  always @(posedge clk) cyc++;

  // FIFO model, pop tracking and per-cycle output comparison.
  always @(negedge clk) begin
    if (!clrn) begin
      model_reset();
      fifo_ready = 1'b0;
      fifo_data  = 8'h00;
    end else begin
      if (!fifo_nextdata_n && !prev_nd) check("pop_width", 32'd2, 32'd1);
      if (evt_valid) check("no_pop_while_valid", {31'd0, fifo_nextdata_n}, 32'd1);

      if (evt_valid) begin
        if (exp_q.size() == 0) check("spurious_event", 32'd1, 32'd0);
        else begin
          e_cur = exp_q[0];
          if (!prev_valid) check("latency", cyc, e_cur.pop_cyc + 2);
          check("evt_code",   {24'd0, evt_code},   {24'd0, e_cur.code});
          check("evt_ext",    {31'd0, evt_ext},    {31'd0, e_cur.ext});
          check("evt_break",  {31'd0, evt_break},  {31'd0, e_cur.brk});
          check("evt_repeat", {31'd0, evt_repeat}, {31'd0, e_cur.rep});
          check("evt_ascii",  {24'd0, evt_ascii},  {24'd0, e_cur.ascii});
          check("shift_held", {31'd0, shift_held}, {31'd0, e_cur.shift});
          check("caps_lock",  {31'd0, caps_lock},  {31'd0, e_cur.caps});
          check("key_cnt",    {24'd0, key_cnt},    {24'd0, e_cur.cnt});
          if (evt_ready) begin
            l_ent = '{evt_code, evt_ext, evt_break, evt_repeat, evt_ascii,
                      shift_held, caps_lock, key_cnt, cyc};
            log_q.push_back(l_ent);
            v_shift = e_cur.shift;
            v_caps  = e_cur.caps;
            v_cnt   = e_cur.cnt;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("idle_shift_held", {31'd0, shift_held}, {31'd0, v_shift});
        check("idle_caps_lock",  {31'd0, caps_lock},  {31'd0, v_caps});
        check("idle_key_cnt",    {24'd0, key_cnt},    {24'd0, v_cnt});
      end

      check("overflow_seen", {31'd0, overflow_seen}, {31'd0, m_ovf});
      m_ovf = m_ovf | fifo_overflow;

      if (!fifo_nextdata_n) begin
        if (fifo_q.size() == 0) check("pop_empty_fifo", 32'd1, 32'd0);
        else begin
          b_pop = fifo_q.pop_front();
          pops++;
          model_byte(b_pop, cyc);
        end
      end
      prev_nd    = fifo_nextdata_n;
      prev_valid = evt_valid;
      fifo_ready = (fifo_q.size() != 0);
      fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    int stable = 0;
    while (stable < 4 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !evt_valid) stable++;
      else stable = 0;
    end
    check("idle_reached", stable, 32'd4);
  endtask

  task automatic push_rand();
    logic [7:0] c;
    logic       ext, brk;
    int         r = $urandom % 16;
    c = (r < 12) ? RAND_POOL[r] : 8'($urandom % 256);
    if (c == 8'hE0 || c == 8'hF0) c = 8'h1C;
    ext = ($urandom % 5 == 0);
    brk = ($urandom % 3 == 0);
    if (ext && (c == 8'h12 || c == 8'h59 || c == 8'h58)) c = 8'h75;
    if (ext) begin
      push(8'hE0);
      if ($urandom % 4 == 0) push(8'hE0);
    end
    if (brk) push(8'hF0);
    push(c);
  endtask

  initial begin
    int base;
    int p0;
    int n;
    clrn          = 1'b0;
    evt_ready     = 1'b1;
    fifo_overflow = 1'b0;
    fifo_ready    = 1'b0;
    fifo_data     = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    @(negedge clk);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_nextdata_n", {31'd0, fifo_nextdata_n}, 32'd1);
    check("rst_key_cnt", {24'd0, key_cnt}, 32'd0);

    // Press and release of 'a'.
    base = log_q.size();
    push(8'h1C); push(8'hF0); push(8'h1C);
    wait_idle(200);
    check("t1_events", log_q.size() - base, 32'd2);
    if (log_q.size() >= base + 2) begin
      check("t1_press_ascii", {24'd0, log_q[base].ascii}, 32'h61);
      check("t1_press_cnt", {24'd0, log_q[base].cnt}, 32'd1);
      check("t1_break", {31'd0, log_q[base+1].brk}, 32'd1);
      check("t1_break_ascii", {24'd0, log_q[base+1].ascii}, 32'h00);
    end

    // Shift held around a letter press.
    base = log_q.size();
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
    wait_idle(300);
    check("t2_events", log_q.size() - base, 32'd4);
    if (log_q.size() >= base + 4) begin
      check("t2_shift_set", {31'd0, log_q[base].shift}, 32'd1);
      check("t2_upper_a", {24'd0, log_q[base+1].ascii}, 32'h41);
      check("t2_shift_clr", {31'd0, log_q[base+3].shift}, 32'd0);
    end

    // CapsLock toggling on and off.
    base = log_q.size();
    push(8'h58); push(8'hF0); push(8'h58); push(8'h32);
    push(8'h58); push(8'h32);
    wait_idle(300);
    check("t3_events", log_q.size() - base, 32'd5);
    if (log_q.size() >= base + 5) begin
      check("t3_caps_on", {31'd0, log_q[base].caps}, 32'd1);
      check("t3_upper_b", {24'd0, log_q[base+2].ascii}, 32'h42);
      check("t3_caps_off", {31'd0, log_q[base+3].caps}, 32'd0);
      check("t3_lower_b", {24'd0, log_q[base+4].ascii}, 32'h62);
    end

    // Typematic repeats.
    base = log_q.size();
    push(8'h1C); push(8'h1C); push(8'h1C);
    wait_idle(300);
    check("t4_events", log_q.size() - base, 32'd3);
    if (log_q.size() >= base + 3) begin
      check("t4_rep0", {31'd0, log_q[base].rep}, 32'd0);
      check("t4_rep1", {31'd0, log_q[base+1].rep}, 32'd1);
      check("t4_rep2", {31'd0, log_q[base+2].rep}, 32'd1);
      check("t4_cnt_flat", {24'd0, log_q[base+2].cnt}, {24'd0, log_q[base].cnt});
    end

    // Extended press/release and their pop counts.
    base = log_q.size();
    p0 = pops;
    push(8'hE0); push(8'h75);
    wait_idle(200);
    check("t5_pops_press", pops - p0, 32'd2);
    p0 = pops;
    push(8'hE0); push(8'hF0); push(8'h75);
    wait_idle(200);
    check("t5_pops_break", pops - p0, 32'd3);
    if (log_q.size() >= base + 2) begin
      check("t5_ext", {31'd0, log_q[base].ext}, 32'd1);
      check("t5_code", {24'd0, log_q[base].code}, 32'h75);
      check("t5_ascii", {24'd0, log_q[base].ascii}, 32'h00);
      check("t5_break", {31'd0, log_q[base+1].brk}, 32'd1);
    end else check("t5_events", log_q.size() - base, 32'd2);

    // Backpressure: bytes stay queued while the event is stalled.
    evt_ready = 1'b0;
    p0 = pops;
    push(8'h1C); push(8'h32); push(8'h21);
    repeat (20) @(posedge clk);
    #1;
    check("bp_pops", pops - p0, 32'd1);
    check("bp_valid", {31'd0, evt_valid}, 32'd1);
    check("bp_code", {24'd0, evt_code}, 32'h1C);
    check("bp_nextdata_n", {31'd0, fifo_nextdata_n}, 32'd1);
    evt_ready = 1'b1;
    wait_idle(300);

    // Randomized traffic with random downstream stalls and overflow pulses.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      evt_ready     = ($urandom % 10 < 7);
      fifo_overflow = ($urandom % 200 == 0);
      if (fifo_q.size() < 3) push_rand();
    end
    fifo_overflow = 1'b0;
    evt_ready     = 1'b1;
    wait_idle(3000);

    // Sticky overflow, then reset in the middle of an E0 prefix.
    @(posedge clk); #1 fifo_overflow = 1'b1;
    @(posedge clk); #1 fifo_overflow = 1'b0;
    push(8'h58); push(8'h12);
    wait_idle(200);
    check("ovf_sticky", {31'd0, overflow_seen}, 32'd1);
    check("pre_rst_shift", {31'd0, shift_held}, 32'd1);
    p0 = pops;
    push(8'hE0);
    n = 0;
    while (pops == p0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("e0_popped", pops - p0, 32'd1);
    repeat (3) @(posedge clk);
    #1 clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    @(negedge clk);
    check("rst2_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst2_evt_code", {24'd0, evt_code}, 32'd0);
    check("rst2_nextdata_n", {31'd0, fifo_nextdata_n}, 32'd1);
    check("rst2_shift", {31'd0, shift_held}, 32'd0);
    check("rst2_caps", {31'd0, caps_lock}, 32'd0);
    check("rst2_cnt", {24'd0, key_cnt}, 32'd0);
    check("rst2_ovf", {31'd0, overflow_seen}, 32'd0);
    base = log_q.size();
    push(8'h74);
    wait_idle(200);
    if (log_q.size() > base) begin
      check("post_rst_ext", {31'd0, log_q[base].ext}, 32'd0);
      check("post_rst_code", {24'd0, log_q[base].code}, 32'h74);
    end else check("post_rst_events", log_q.size() - base, 32'd1);

    // key_cnt wrap: 260 further non-repeat presses from a count of 1.
    for (int i = 0; i < 260; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
    wait_idle(5000);
    check("cnt_wrap", {24'd0, key_cnt}, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
